// File: rtl/spi_reg_frame.sv
// rtl/spi_reg_frame.sv - SPI slave exposing an 8x8 config bank (write) and 8x8 status bank (read)
// Optional feature macro: SPI_CFG_READBACK_EN (read frames with sel=1 return the config register)
module spi_reg_frame #(
   parameter int NUM_CFG    = 8,
   parameter int NUM_STATUS = 8,
   parameter int REG_WIDTH  = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ena,
   input  logic [1:0]                       mode,
   input  logic                             spi_cs_n,
   input  logic                             spi_clk,
   input  logic                             spi_mosi,
   output logic                             spi_miso,
   output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
   input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
   output logic                             cfg_wr_stb,
   output logic [2:0]                       cfg_wr_addr
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   state_t                         state_q, state_d;
   logic [3:0]                     cnt_q, cnt_d;
   logic [1:0]                     mode_q;
   logic                           cs_n_q;
   logic                           sclk_q;
   logic [6:0]                     rx_q;
   logic                           rw_q;
   logic [2:0]                     addr_q;
   logic [7:0]                     tx_q;
   logic                           loaded_q;
   logic [NUM_CFG*REG_WIDTH-1:0]   cfg_q;
   logic                           stb_q;
   logic [2:0]                     wr_addr_q;

   logic cpol, cpha, lead_e, trail_e, sample_e, shift_e, cs_fall;
   logic take_cmd, commit;
   logic [7:0] rd_val;

   // Edge classification is relative to the mode latched for the current frame
   assign cpol     = mode_q[1];
   assign cpha     = mode_q[0];
   assign lead_e   = (sclk_q == cpol) && (spi_clk != cpol);
   assign trail_e  = (sclk_q != cpol) && (spi_clk == cpol);
   assign sample_e = cpha ? trail_e : lead_e;
   assign shift_e  = cpha ? lead_e  : trail_e;
   assign cs_fall  = cs_n_q && !spi_cs_n;

`ifdef SPI_CFG_READBACK_EN
   logic sel_q;
   assign rd_val = sel_q ? cfg_q[{addr_q, 3'b000} +: 8] : status_regs[{addr_q, 3'b000} +: 8];
`else
   assign rd_val = status_regs[{addr_q, 3'b000} +: 8];
`endif

   assign spi_miso    = tx_q[7];
   assign config_regs = cfg_q;
   assign cfg_wr_stb  = stb_q;
   assign cfg_wr_addr = wr_addr_q;

   // Frame sequencing; chip-select release overrides any same-cycle sample edge
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      take_cmd = 1'b0;
      commit   = 1'b0;
      if (spi_cs_n) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = 4'd0;
               if (cs_fall) state_d = CMD;
            end
            CMD: begin
               if (sample_e) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     state_d  = DATA;
                     take_cmd = 1'b1;
                  end
               end
            end
            DATA: begin
               if (sample_e) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     state_d = DONE;
                     commit  = rw_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else if (ena) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Datapath: receive shifter, command capture, config commit and read shifter
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= 2'b00;
         cs_n_q    <= 1'b0;
         sclk_q    <= 1'b0;
         rx_q      <= '0;
         rw_q      <= 1'b0;
         addr_q    <= 3'd0;
         tx_q      <= 8'd0;
         loaded_q  <= 1'b0;
         cfg_q     <= '0;
         stb_q     <= 1'b0;
         wr_addr_q <= 3'd0;
`ifdef SPI_CFG_READBACK_EN
         sel_q     <= 1'b0;
`endif
      end else if (ena) begin
         cs_n_q <= spi_cs_n;
         sclk_q <= spi_clk;
         if (state_q == IDLE && state_d == CMD) mode_q <= mode;
         if (sample_e && !spi_cs_n && (state_q == CMD || state_q == DATA))
            rx_q <= {rx_q[5:0], spi_mosi};
         if (take_cmd) begin
            rw_q   <= rx_q[6];
            addr_q <= {rx_q[1:0], spi_mosi};
`ifdef SPI_CFG_READBACK_EN
            sel_q  <= rx_q[2];
`endif
         end
         stb_q <= commit;
         if (commit) begin
            cfg_q[{addr_q, 3'b000} +: 8] <= {rx_q, spi_mosi};
            wr_addr_q                    <= addr_q;
         end
         if (state_q == DATA && state_d == DATA && !rw_q) begin
            if (shift_e) begin
               if (!loaded_q) begin
                  tx_q     <= rd_val;
                  loaded_q <= 1'b1;
               end else begin
                  tx_q <= {tx_q[6:0], 1'b0};
               end
            end
         end else begin
            tx_q     <= 8'd0;
            loaded_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_frame.sv
// tb/tb_spi_reg_frame.sv - scoreboard bench for spi_reg_frame
module tb_spi_reg_frame;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b1;
   logic [1:0]  mode = 2'b00;
   logic        spi_cs_n = 1'b1;
   logic        spi_clk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [63:0] config_regs;
   logic [63:0] status_regs = 64'h0;
   logic        cfg_wr_stb;
   logic [2:0]  cfg_wr_addr;

   int checks = 0;
   int failures = 0;
   int stb_count = 0;

   typedef struct {
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t         wr_exp_q[$];
   logic [7:0]  rd_exp_q[$];
   logic [63:0] cfg_model = 64'h0;

   spi_reg_frame dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .mode        (mode),
      .spi_cs_n    (spi_cs_n),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .config_regs (config_regs),
      .status_regs (status_regs),
      .cfg_wr_stb  (cfg_wr_stb),
      .cfg_wr_addr (cfg_wr_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      wr_exp_q.push_back(e);
      cfg_model[int'(a)*8 +: 8] = d;
   endtask

   // SPI master: drives one frame, captures miso at the master's sample points
   task automatic spi_frame(input logic [1:0] m, input logic [15:0] word, input int nbits,
                            input int rst_after, output logic [15:0] rx);
      logic cpol, cpha, b;
      cpol = m[1];
      cpha = m[0];
      rx = 16'h0;
      mode = m;
      spi_clk = cpol;
      spi_mosi = 1'b0;
      spi_cs_n = 1'b1;
      clks(4);
      spi_cs_n = 1'b0;
      clks(1);
      mode = ~m;
      clks(3);
      for (int i = 0; i < nbits; i++) begin
         b = (i < 16) ? word[15-i] : 1'b1;
         if (i == rst_after) begin
            rst = 1'b1;
            clks(1);
            rst = 1'b0;
            cfg_model = 64'h0;
            clks(2);
         end
         if (!cpha) begin
            spi_mosi = b;
            clks(4);
            if (i < 16) rx[15-i] = spi_miso;
            spi_clk = ~cpol;
            clks(4);
            spi_clk = cpol;
         end else begin
            spi_clk = ~cpol;
            clks(2);
            spi_mosi = b;
            clks(2);
            if (i < 16) rx[15-i] = spi_miso;
            spi_clk = cpol;
            clks(4);
         end
      end
      clks(4);
      spi_cs_n = 1'b1;
      clks(4);
   endtask

   // Scoreboard consumer for config write commits
   always @(negedge clk) begin
      if (cfg_wr_stb) begin
         wr_t e;
         stb_count++;
         check("stb_expected", 64'(wr_exp_q.size() != 0), 64'd1);
         if (wr_exp_q.size() != 0) begin
            e = wr_exp_q.pop_front();
            check("stb_addr", 64'(cfg_wr_addr), 64'(e.addr));
            check("stb_data", 64'(config_regs[int'(e.addr)*8 +: 8]), 64'(e.data));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rx;
      logic [7:0]  exp_rd;
      int          stb_before;

      status_regs[6*8 +: 8] = 8'hC4;
      status_regs[5*8 +: 8] = 8'h5B;
      status_regs[0*8 +: 8] = 8'h3C;
      clks(3);
      rst = 1'b0;
      clks(1);
      check("rst_miso", 64'(spi_miso), 64'd0);
      check("rst_stb", 64'(cfg_wr_stb), 64'd0);
      check("rst_wr_addr", 64'(cfg_wr_addr), 64'd0);
      check("rst_cfg", config_regs, 64'h0);

      // Mode 0 write 0x83 0x5A
      push_wr(3'd3, 8'h5A);
      spi_frame(2'b00, 16'h835A, 16, -1, rx);
      check("m0_wr_done", 64'(wr_exp_q.size()), 64'd0);
      check("m0_wr_bank", config_regs, cfg_model);
      check("m0_wr_addr", 64'(cfg_wr_addr), 64'd3);
      check("m0_wr_miso", 64'(rx), 64'd0);

      // Mode 3 read of status reg 6
      stb_before = stb_count;
      rd_exp_q.push_back(8'hC4);
      spi_frame(2'b11, 16'h0600, 16, -1, rx);
      exp_rd = rd_exp_q.pop_front();
      check("m3_rd_data", 64'(rx[7:0]), 64'(exp_rd));
      check("m3_rd_cmd_miso", 64'(rx[15:8]), 64'd0);
      check("m3_rd_bank", config_regs, cfg_model);
      check("m3_rd_nostb", 64'(stb_count - stb_before), 64'd0);

      // Mode 1 write aborted after 12 bits
      stb_before = stb_count;
      spi_frame(2'b01, 16'h81FF, 12, -1, rx);
      check("m1_abort_bank", config_regs, cfg_model);
      check("m1_abort_nostb", 64'(stb_count - stb_before), 64'd0);

      // Mode 2 write with 8 trailing extra clocks
      stb_before = stb_count;
      push_wr(3'd7, 8'hFF);
      spi_frame(2'b10, 16'h87FF, 24, -1, rx);
      check("m2_extra_done", 64'(wr_exp_q.size()), 64'd0);
      check("m2_extra_bank", config_regs, cfg_model);
      check("m2_extra_one_stb", 64'(stb_count - stb_before), 64'd1);

      // Reset after bit 10 discards frame, then a clean write
      stb_before = stb_count;
      spi_frame(2'b00, 16'h8233, 16, 10, rx);
      check("rst_mid_bank", config_regs, 64'h0);
      check("rst_mid_nostb", 64'(stb_count - stb_before), 64'd0);
      push_wr(3'd2, 8'h44);
      spi_frame(2'b00, 16'h8244, 16, -1, rx);
      check("rst_clean_bank", config_regs, cfg_model);
      check("rst_clean_done", 64'(wr_exp_q.size()), 64'd0);

      // Mode 0 read with reserved bits set
      rd_exp_q.push_back(8'h5B);
      spi_frame(2'b00, 16'h7500, 16, -1, rx);
      exp_rd = rd_exp_q.pop_front();
      check("m0_rd_reserved", 64'(rx[7:0]), 64'(exp_rd));

      // Readback selection
      push_wr(3'd0, 8'hA5);
      spi_frame(2'b00, 16'h80A5, 16, -1, rx);
`ifdef SPI_CFG_READBACK_EN
      rd_exp_q.push_back(8'hA5);
`else
      rd_exp_q.push_back(8'h3C);
`endif
      spi_frame(2'b01, 16'h0800, 16, -1, rx);
      exp_rd = rd_exp_q.pop_front();
      check("readback_sel", 64'(rx[7:0]), 64'(exp_rd));
      check("readback_bank", config_regs, cfg_model);

      // Clock enable low: frame ignored, then normal mode 1 write
      stb_before = stb_count;
      ena = 1'b0;
      spi_frame(2'b00, 16'h8111, 16, -1, rx);
      ena = 1'b1;
      clks(2);
      check("ena_low_bank", config_regs, cfg_model);
      check("ena_low_nostb", 64'(stb_count - stb_before), 64'd0);
      push_wr(3'd5, 8'h66);
      spi_frame(2'b01, 16'h8566, 16, -1, rx);
      check("m1_wr_bank", config_regs, cfg_model);
      check("m1_wr_done", 64'(wr_exp_q.size()), 64'd0);

      clks(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
